// File: rtl/cpu_regfile_bytewise.sv
// Register file with masked write, inc/dec, 8-bit narrow mode and a byte-serial load sequencer.
// Optional second read port is enabled with CPU_REGFILE_DBG_EN.
module cpu_regfile_bytewise #(
  parameter int               WIDTH       = 16,
  parameter int               NUM_REGS    = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        cpu_en,
  input  logic [$clog2(NUM_REGS)-1:0] rsel,
  output logic [WIDTH-1:0]            rdata,
  input  logic [1:0]                  op,
  input  logic [WIDTH-1:0]            wdata,
  input  logic [WIDTH-1:0]            wmask,
  input  logic                        narrow,
  output logic                        flag_z,
  output logic                        flag_n,
  input  logic                        load_start,
  input  logic [7:0]                  bus_byte,
  input  logic                        byte_valid,
  output logic                        byte_ready,
  output logic                        busy,
`ifdef CPU_REGFILE_DBG_EN
  input  logic [$clog2(NUM_REGS)-1:0] dbg_rsel,
  output logic [WIDTH-1:0]            dbg_rdata,
`endif
  output logic                        load_done
);
  localparam int SEL_W = $clog2(NUM_REGS);
  localparam int NB    = WIDTH / 8;
  localparam int CNT_W = $clog2(NB + 1);
  localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(8'hFF);

  localparam logic [1:0] OP_NOP = 2'b00, OP_WR = 2'b01, OP_INC = 2'b10, OP_DEC = 2'b11;

  typedef enum logic {IDLE, LOAD} state_t;

  logic [NUM_REGS-1:0][WIDTH-1:0] regs;
  state_t                         state, state_nxt;
  logic [SEL_W-1:0]               target;
  logic [CNT_W-1:0]               cnt, nbytes;
  logic                           ld_narrow;
  logic [WIDTH-1:0]               shadow, shadow_nxt, commit_val;
  logic [WIDTH-1:0]               cur, m, res;
  logic [7:0]                     low_res;
  logic                           exec, start, accept, last;

  assign rdata = regs[rsel];
`ifdef CPU_REGFILE_DBG_EN
  assign dbg_rdata = regs[dbg_rsel];
`endif

  assign busy       = (state == LOAD);
  assign byte_ready = busy && cpu_en;
  assign exec       = cpu_en && !busy && (op != OP_NOP);
  assign start      = cpu_en && !busy && load_start;
  assign accept     = byte_ready && byte_valid;
  assign last       = accept && (cnt == nbytes - CNT_W'(1));

  // Op datapath: narrow mode confines every change to the low byte.
  assign cur = regs[rsel];
  always_comb begin
    m       = narrow ? (wmask & LOW_MASK) : wmask;
    low_res = (op == OP_DEC) ? cur[7:0] - 8'd1 : cur[7:0] + 8'd1;
    res     = cur;
    case (op)
      OP_WR:  res = (cur & ~m) | (wdata & m);
      OP_INC: res = narrow ? ((cur & ~LOW_MASK) | WIDTH'(low_res)) : cur + WIDTH'(1);
      OP_DEC: res = narrow ? ((cur & ~LOW_MASK) | WIDTH'(low_res)) : cur - WIDTH'(1);
      default: res = cur;
    endcase
  end

  // Shadow with the in-flight byte merged so the final byte commits in the same edge.
  always_comb begin
    shadow_nxt = shadow;
    for (int b = 0; b < NB; b++)
      if (cnt == CNT_W'(b)) shadow_nxt[8*b +: 8] = bus_byte;
    commit_val = ld_narrow ? ((regs[target] & ~LOW_MASK) | (shadow_nxt & LOW_MASK))
                           : shadow_nxt;
  end

  genvar i;
  generate
    for (i = 0; i < NUM_REGS; i++) begin : g_reg
      always_ff @(posedge clk) begin
        if (!reset_n)                            regs[i] <= RESET_VALUE;
        else if (exec && rsel == SEL_W'(i))      regs[i] <= res;
        else if (last && target == SEL_W'(i))    regs[i] <= commit_val;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (exec) begin
      flag_z <= narrow ? (res[7:0] == 8'd0) : (res == '0);
      flag_n <= narrow ? res[7] : res[WIDTH-1];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      target    <= '0;
      cnt       <= '0;
      nbytes    <= '0;
      ld_narrow <= 1'b0;
      shadow    <= '0;
      load_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      load_done <= last;
      if (start) begin
        target    <= rsel;
        cnt       <= '0;
        nbytes    <= narrow ? CNT_W'(1) : CNT_W'(NB);
        ld_narrow <= narrow;
        shadow    <= '0;
      end else if (accept) begin
        shadow <= shadow_nxt;
        cnt    <= cnt + CNT_W'(1);
      end
    end
  end
endmodule
